// File: rtl/irq_pkg.sv
// irq_pkg: shared state type and default sizing for the interrupt arbiter.
package irq_pkg;

  localparam int N_IRQ_DEF = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_state_t;

endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: interrupt lines, masks and the core handshake bundled
// together. The arbiter is the slave; the core/peripheral side is the master.
interface irq_arbiter_if
  import irq_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int ID_W  = $clog2(N_IRQ)
) ();

  logic [N_IRQ-1:0] irq_i;
  logic [N_IRQ-1:0] irq_edge_i;
  logic [N_IRQ-1:0] irq_en_i;
  logic             gie_i;
  logic             ack_i;
  logic             done_i;
  logic             inti;
  logic [ID_W-1:0]  irq_id_o;
  logic [N_IRQ-1:0] pending_o;
  logic             busy_o;

  modport slave (
    input  irq_i, irq_edge_i, irq_en_i, gie_i, ack_i, done_i,
    output inti, irq_id_o, pending_o, busy_o
  );

  modport master (
    output irq_i, irq_edge_i, irq_en_i, gie_i, ack_i, done_i,
    input  inti, irq_id_o, pending_o, busy_o
  );

endinterface

// File: rtl/irq_prio_sel.sv
// irq_prio_sel: picks one winner from the eligible vector. Fixed priority
// starts the scan at line 0; round-robin starts it at rr_ptr and wraps.
module irq_prio_sel
  import irq_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int ID_W  = $clog2(N_IRQ),
  parameter int RR_EN = 0
) (
  input  logic [N_IRQ-1:0] eligible,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  int              base;
  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Scan from the farthest offset back to offset 0 so the closest eligible line is the last one written
  always_comb begin
    valid    = 1'b0;
    id       = '0;
    base     = (RR_EN != 0) ? int'(rr_ptr) : 0;
    cand     = 0;
    cand_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      cand     = (base + i) % N_IRQ;
      cand_idx = ID_W'(cand);
      if (eligible[cand_idx]) begin
        valid = 1'b1;
        id    = cand_idx;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches interrupt lines, masks them, and hands one at a time
// to the core through a request/ack/done handshake (no nesting).
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int ID_W  = $clog2(N_IRQ),
  parameter int RR_EN = 0
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  irq_arbiter_if.slave  bus
);

  irq_state_t       state;
  irq_state_t       next_state;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] pending_next;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] eligible;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  sel_id;
  logic             sel_valid;
  logic             grant;
  logic             take_ack;
  logic             take_done;

  assign rise     = bus.irq_i & ~prev_q;
  assign eligible = pending & bus.irq_en_i;

  irq_prio_sel #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W),
    .RR_EN (RR_EN)
  ) u_sel (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .valid    (sel_valid),
    .id       (sel_id)
  );

  // Handshake FSM: commit to a winner in IDLE, wait for ack, then wait for done
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    take_ack   = 1'b0;
    take_done  = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (bus.gie_i && sel_valid) begin
          grant      = 1'b1;
          next_state = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        if (bus.ack_i) begin
          take_ack   = 1'b1;
          next_state = IRQ_SERVICE;
        end
      end
      IRQ_SERVICE: begin
        if (bus.done_i) begin
          take_done  = 1'b1;
          next_state = IRQ_IDLE;
        end
      end
      default: next_state = IRQ_IDLE;
    endcase
  end

  // Next pending value: edge lines hold until acked (a new edge wins), level lines follow the pin
  always_comb begin
    clr          = '0;
    pending_next = '0;
    if (take_ack) clr[id_q] = 1'b1;
    for (int k = 0; k < N_IRQ; k++) begin
      if (bus.irq_edge_i[k]) pending_next[k] = (pending[k] & ~clr[k]) | rise[k];
      else                   pending_next[k] = bus.irq_i[k];
    end
  end

  // State register
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) state <= IRQ_IDLE;
    else          state <= next_state;
  end

  // Line history for edge detection and the pending register
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      prev_q  <= '0;
      pending <= '0;
    end else begin
      prev_q  <= bus.irq_i;
      pending <= pending_next;
    end
  end

  // Capture the granted id and move the round-robin pointer past it when the handler ends
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      id_q   <= '0;
      rr_ptr <= '0;
    end else begin
      if (grant) id_q <= sel_id;
      if (take_done && (RR_EN != 0))
        rr_ptr <= (id_q == ID_W'(N_IRQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  assign bus.inti      = (state == IRQ_REQ);
  assign bus.irq_id_o  = id_q;
  assign bus.pending_o = pending;
  assign bus.busy_o    = (state != IRQ_IDLE);

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: drives a fixed-priority and a round-robin arbiter with the
// same stimulus and compares both against a cycle-level reference model.
module tb_irq_arbiter;
  import irq_pkg::*;

  localparam int N    = 4;
  localparam int ID_W = $clog2(N);

  logic         clk;
  logic         rst_n;
  logic [N-1:0] irq;
  logic [N-1:0] irq_edge;
  logic [N-1:0] irq_en;
  logic         gie;
  logic         ack;
  logic         done;

  int checks = 0;
  int errors = 0;
  int episodes_fp = 0;
  logic last_inti_fp = 1'b0;

  // Reference model state, index 0 = fixed priority, 1 = round-robin
  bit [N-1:0] m_pend [2];
  bit [N-1:0] m_prev;
  int         m_phase [2];
  int         m_id [2];
  int         m_ptr [2];

  irq_arbiter_if #(.N_IRQ(N)) bus_fp ();
  irq_arbiter_if #(.N_IRQ(N)) bus_rr ();

  assign bus_fp.irq_i      = irq;
  assign bus_fp.irq_edge_i = irq_edge;
  assign bus_fp.irq_en_i   = irq_en;
  assign bus_fp.gie_i      = gie;
  assign bus_fp.ack_i      = ack;
  assign bus_fp.done_i     = done;
  assign bus_rr.irq_i      = irq;
  assign bus_rr.irq_edge_i = irq_edge;
  assign bus_rr.irq_en_i   = irq_en;
  assign bus_rr.gie_i      = gie;
  assign bus_rr.ack_i      = ack;
  assign bus_rr.done_i     = done;

  irq_arbiter #(.N_IRQ(N), .RR_EN(0)) dut_fp (.CLK_I(clk), .RST_N_I(rst_n), .bus(bus_fp));
  irq_arbiter #(.N_IRQ(N), .RR_EN(1)) dut_rr (.CLK_I(clk), .RST_N_I(rst_n), .bus(bus_rr));

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic obs_inti(input int d);
    return (d != 0) ? bus_rr.inti : bus_fp.inti;
  endfunction

  function automatic logic obs_busy(input int d);
    return (d != 0) ? bus_rr.busy_o : bus_fp.busy_o;
  endfunction

  function automatic logic [ID_W-1:0] obs_id(input int d);
    return (d != 0) ? bus_rr.irq_id_o : bus_fp.irq_id_o;
  endfunction

  function automatic logic [N-1:0] obs_pend(input int d);
    return (d != 0) ? bus_rr.pending_o : bus_fp.pending_o;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = '0;
      m_phase[d] = 0;
      m_id[d]    = 0;
      m_ptr[d]   = 0;
    end
    m_prev = '0;
  endfunction

  // First pending-and-enabled line scanning upward from the start point, or -1
  function automatic int model_pick(input int d);
    int start = (d == 1) ? m_ptr[d] : 0;
    for (int i = 0; i < N; i++) begin
      int k = (start + i) % N;
      if (m_pend[d][k] && irq_en[k]) return k;
    end
    return -1;
  endfunction

  // One clock of the model using the inputs as they stand before the edge
  function automatic void model_step(input int d);
    bit [N-1:0] rise = irq & ~m_prev;
    int cleared = -1;
    int win;
    case (m_phase[d])
      0: begin
        if (gie) begin
          win = model_pick(d);
          if (win >= 0) begin
            m_id[d]    = win;
            m_phase[d] = 1;
          end
        end
      end
      1: begin
        if (ack) begin
          cleared    = m_id[d];
          m_phase[d] = 2;
        end
      end
      default: begin
        if (done) begin
          m_phase[d] = 0;
          if (d == 1) m_ptr[d] = (m_id[d] + 1) % N;
        end
      end
    endcase
    for (int k = 0; k < N; k++) begin
      if (irq_edge[k]) m_pend[d][k] = (m_pend[d][k] && (k != cleared)) || rise[k];
      else             m_pend[d][k] = irq[k];
    end
  endfunction

  task automatic compare_model();
    for (int d = 0; d < 2; d++) begin
      string sfx = (d != 0) ? "rr" : "fp";
      check_output({"inti_", sfx}, obs_inti(d), (m_phase[d] == 1));
      check_output({"busy_", sfx}, obs_busy(d), (m_phase[d] != 0));
      check_output({"id_", sfx},   obs_id(d),   m_id[d]);
      check_output({"pend_", sfx}, obs_pend(d), m_pend[d]);
    end
  endtask

  task automatic apply_stimulus();
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
      m_prev = irq;
    end
    @(posedge clk);
    #1;
    if (bus_fp.inti && !last_inti_fp) episodes_fp++;
    last_inti_fp = bus_fp.inti;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    last_inti_fp = 1'b0;
    compare_model();
    apply_stimulus();
    apply_stimulus();
    rst_n = 1'b1;
  endtask

  task automatic serve();
    ack = 1'b1;
    apply_stimulus();
    ack  = 1'b0;
    done = 1'b1;
    apply_stimulus();
    done = 1'b0;
  endtask

  task automatic wait_req(input int d, input int budget);
    int n = 0;
    while (!obs_inti(d) && n < budget) begin
      apply_stimulus();
      n++;
    end
    check_output("wait_req", obs_inti(d), 1'b1);
  endtask

  initial begin
    int ep0;
    rst_n    = 1'b0;
    irq      = '1;
    irq_edge = '1;
    irq_en   = '1;
    gie      = 1'b1;
    ack      = 1'b0;
    done     = 1'b0;

    $display("[TB] reset with all lines high");
    do_reset();
    check_output("rst_inti", bus_fp.inti, 1'b0);
    check_output("rst_busy", bus_fp.busy_o, 1'b0);
    check_output("rst_pend", bus_fp.pending_o, 4'b0000);
    irq = '0;
    apply_stimulus();
    apply_stimulus();

    $display("[TB] single edge on line 2");
    irq = 4'b0100;
    apply_stimulus();
    irq = 4'b0000;
    check_output("lat_early", bus_fp.inti, 1'b0);
    apply_stimulus();
    check_output("single_inti", bus_fp.inti, 1'b1);
    check_output("single_id", bus_fp.irq_id_o, 2);
    apply_stimulus();
    apply_stimulus();
    ack = 1'b1;
    apply_stimulus();
    ack = 1'b0;
    check_output("ack_inti", bus_fp.inti, 1'b0);
    check_output("ack_pend2", bus_fp.pending_o[2], 1'b0);
    check_output("ack_busy", bus_fp.busy_o, 1'b1);
    done = 1'b1;
    apply_stimulus();
    done = 1'b0;
    check_output("done_busy", bus_fp.busy_o, 1'b0);

    $display("[TB] simultaneous edges on lines 1 and 3");
    ep0 = episodes_fp;
    irq = 4'b1010;
    apply_stimulus();
    irq = 4'b0000;
    apply_stimulus();
    check_output("sim_first_id", bus_fp.irq_id_o, 1);
    serve();
    apply_stimulus();
    check_output("sim_second_inti", bus_fp.inti, 1'b1);
    check_output("sim_second_id", bus_fp.irq_id_o, 3);
    serve();
    for (int i = 0; i < 4; i++) apply_stimulus();
    check_output("sim_episodes", episodes_fp - ep0, 2);

    $display("[TB] round-robin over four level lines");
    irq_edge = 4'b0000;
    irq      = 4'b1111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_req(1, 10);
      check_output("rr_order", bus_rr.irq_id_o, i % N);
      serve();
    end
    irq_edge = 4'b1111;
    irq      = 4'b0000;
    do_reset();

    $display("[TB] masking by line enable and global enable");
    irq_en = 4'b1110;
    irq    = 4'b0001;
    apply_stimulus();
    irq = 4'b0000;
    apply_stimulus();
    apply_stimulus();
    check_output("mask_pend0", bus_fp.pending_o[0], 1'b1);
    check_output("mask_inti", bus_fp.inti, 1'b0);
    irq_en = 4'b1111;
    apply_stimulus();
    check_output("unmask_inti", bus_fp.inti, 1'b1);
    serve();
    gie = 1'b0;
    irq = 4'b0001;
    apply_stimulus();
    irq = 4'b0000;
    for (int i = 0; i < 4; i++) apply_stimulus();
    check_output("gie_inti", bus_fp.inti, 1'b0);
    check_output("gie_pend0", bus_fp.pending_o[0], 1'b1);
    gie = 1'b1;
    apply_stimulus();
    check_output("gie_on_inti", bus_fp.inti, 1'b1);
    serve();

    $display("[TB] re-pend race on line 2");
    irq = 4'b0100;
    apply_stimulus();
    irq = 4'b0000;
    apply_stimulus();
    check_output("race_id", bus_fp.irq_id_o, 2);
    ack = 1'b1;
    irq = 4'b0100;
    apply_stimulus();
    ack = 1'b0;
    irq = 4'b0000;
    check_output("race_pend2", bus_fp.pending_o[2], 1'b1);
    done = 1'b1;
    apply_stimulus();
    done = 1'b0;
    apply_stimulus();
    check_output("race_reissue_inti", bus_fp.inti, 1'b1);
    check_output("race_reissue_id", bus_fp.irq_id_o, 2);
    serve();

    $display("[TB] asynchronous reset while requesting");
    irq = 4'b0010;
    apply_stimulus();
    irq = 4'b0000;
    apply_stimulus();
    check_output("pre_rst_inti", bus_fp.inti, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_inti_fp", bus_fp.inti, 1'b0);
    check_output("async_inti_rr", bus_rr.inti, 1'b0);
    check_output("async_busy", bus_fp.busy_o, 1'b0);
    model_reset();
    last_inti_fp = 1'b0;
    apply_stimulus();
    rst_n = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      irq      = N'($urandom);
      irq_edge = N'($urandom);
      irq_en   = N'($urandom) | N'($urandom);
      gie      = ($urandom_range(0, 7) != 0);
      ack      = ($urandom_range(0, 2) == 0);
      done     = ($urandom_range(0, 2) == 0);
      apply_stimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
